// File: rtl/eval_scheduler_pkg.sv
// Shared definitions for the evaluation-datapath scheduler.
//   - FSM state encoding (IDLE / WAKE / ACTIVE)
//   - requester count, datapath width, response tag width, counter width
//   - tag2onehot: turns a requester tag into a one-hot response strobe
package eval_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAKE   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 8;
  localparam int TAG_W   = $clog2(NUM_REQ);
  // Wide enough for WAKE_CYC and IDLE_HOLD up to 15.
  localparam int CNT_W   = 4;

  function automatic logic [NUM_REQ-1:0] tag2onehot(input logic [TAG_W-1:0] tag);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[tag] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/eval_scheduler_if.sv
// Requester-side bundle of the evaluation scheduler.
//   req_valid/req_ready : per-requester valid/accept handshake
//   req_data1/req_data2 : packed operands, requester i on bits [8i+7:8i]
//   req_kernel          : per-requester kernel_enable mode bit
//   rsp_valid/rsp_data  : one-hot response strobe and result, no backpressure
// master = requesters, slave = scheduler.
interface eval_scheduler_if;
  import eval_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data1;
  logic [NUM_REQ*DATA_W-1:0] req_data2;
  logic [NUM_REQ-1:0]        req_kernel;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;

  modport master (
    output req_valid, req_data1, req_data2, req_kernel,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data1, req_data2, req_kernel,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/eval_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : grants are only issued while high
//   req        : request vector
//   gnt        : combinational one-hot (or zero) grant
// The pointer names the requester favoured on contention; it moves to the
// other requester after every grant, so a lone requester also hands
// priority away.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end

    ptr_d = ptr_q;
    if (gnt[0]) begin
      ptr_d = 1'b1;
    end else if (gnt[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/eval_scheduler.sv
// Front-end controller for the 8-bit evaluation datapath.
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_if (slave)    : two requesters plus the response strobe/data
//   dp_data_in1/2     : registered operands to the datapath
//   dp_kernel_enable  : registered mode bit to the datapath
//   dp_clk_en         : registered datapath clock-gate enable
//   dp_result         : datapath result, valid DP_LAT cycles after dp_* drive
// Arbitrates the requesters round-robin, issues at most one op per cycle,
// tags each op so its result returns to the originator, and gates the
// datapath clock off when idle (with a settle delay on wake).
module eval_scheduler
  import eval_pkg::*;
#(
  parameter int DP_LAT    = 1,
  parameter int WAKE_CYC  = 2,
  parameter int IDLE_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  eval_scheduler_if.slave   req_if,
  output logic [DATA_W-1:0] dp_data_in1,
  output logic [DATA_W-1:0] dp_data_in2,
  output logic              dp_kernel_enable,
  output logic              dp_clk_en,
  input  logic [DATA_W-1:0] dp_result
);

  localparam logic [CNT_W-1:0] WAKE_TC = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_TC = CNT_W'(IDLE_HOLD - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wake_cnt_q, wake_cnt_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic               dp_clk_en_q, dp_clk_en_d;
  logic [DATA_W-1:0]  dp_data_in1_q, dp_data_in1_d;
  logic [DATA_W-1:0]  dp_data_in2_q, dp_data_in2_d;
  logic               dp_kernel_q, dp_kernel_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

  // Tracker: stage k holds the op issued k+1 edges ago. The entry in the
  // last stage lines up with dp_result on the current edge.
  logic [DP_LAT:0]            trk_vld_q, trk_vld_d;
  logic [DP_LAT:0][TAG_W-1:0] trk_tag_q, trk_tag_d;

  logic [NUM_REQ-1:0] gnt;
  logic [TAG_W-1:0]   gnt_idx;
  logic               xfer;
  logic               idle_cyc;

  // Unpacked per-requester operand views.
  logic [DATA_W-1:0] op1 [NUM_REQ];
  logic [DATA_W-1:0] op2 [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign op1[gi] = req_if.req_data1[gi*DATA_W +: DATA_W];
    assign op2[gi] = req_if.req_data2[gi*DATA_W +: DATA_W];
  end

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == ACTIVE),
    .req   (req_if.req_valid),
    .gnt   (gnt)
  );

  assign req_if.req_ready = gnt;
  assign gnt_idx          = gnt[1];
  assign xfer             = |(req_if.req_valid & gnt);
  // An idle cycle needs both no pending request and nothing in flight, so
  // the clock can never be gated while a result is still on its way.
  assign idle_cyc         = !(|req_if.req_valid) && !(|trk_vld_q);

  // State, wake/idle counters and clock-gate enable.
  always_comb begin
    state_d     = state_q;
    wake_cnt_d  = wake_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    dp_clk_en_d = dp_clk_en_q;

    case (state_q)
      IDLE: begin
        dp_clk_en_d = 1'b0;
        wake_cnt_d  = '0;
        idle_cnt_d  = '0;
        if (|req_if.req_valid) begin
          state_d     = WAKE;
          dp_clk_en_d = 1'b1;
        end
      end

      WAKE: begin
        dp_clk_en_d = 1'b1;
        idle_cnt_d  = '0;
        if (wake_cnt_q == WAKE_TC) begin
          state_d    = ACTIVE;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + 1'b1;
        end
      end

      ACTIVE: begin
        dp_clk_en_d = 1'b1;
        wake_cnt_d  = '0;
        // A request showing up on the terminal idle cycle makes this cycle
        // non-idle, so the block stays awake and the grant goes through.
        if (idle_cyc) begin
          if (idle_cnt_q == IDLE_TC) begin
            state_d     = IDLE;
            dp_clk_en_d = 1'b0;
            idle_cnt_d  = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end else begin
          idle_cnt_d = '0;
        end
      end

      default: begin
        state_d     = IDLE;
        dp_clk_en_d = 1'b0;
        wake_cnt_d  = '0;
        idle_cnt_d  = '0;
      end
    endcase
  end

  // Operand issue, tracker shift and response capture.
  always_comb begin
    dp_data_in1_d = dp_data_in1_q;
    dp_data_in2_d = dp_data_in2_q;
    dp_kernel_d   = dp_kernel_q;
    trk_vld_d     = trk_vld_q;
    trk_tag_d     = trk_tag_q;
    rsp_valid_d   = '0;
    rsp_data_d    = rsp_data_q;

    if (xfer) begin
      dp_data_in1_d = op1[gnt_idx];
      dp_data_in2_d = op2[gnt_idx];
      dp_kernel_d   = req_if.req_kernel[gnt_idx];
    end

    if (dp_clk_en_q) begin
      trk_vld_d = {trk_vld_q[DP_LAT-1:0], xfer};
      trk_tag_d = {trk_tag_q[DP_LAT-1:0], gnt_idx};
      if (trk_vld_q[DP_LAT]) begin
        rsp_valid_d = tag2onehot(trk_tag_q[DP_LAT]);
        rsp_data_d  = dp_result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wake_cnt_q    <= '0;
      idle_cnt_q    <= '0;
      dp_clk_en_q   <= 1'b0;
      dp_data_in1_q <= '0;
      dp_data_in2_q <= '0;
      dp_kernel_q   <= 1'b0;
      trk_vld_q     <= '0;
      trk_tag_q     <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      wake_cnt_q    <= wake_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      dp_clk_en_q   <= dp_clk_en_d;
      dp_data_in1_q <= dp_data_in1_d;
      dp_data_in2_q <= dp_data_in2_d;
      dp_kernel_q   <= dp_kernel_d;
      trk_vld_q     <= trk_vld_d;
      trk_tag_q     <= trk_tag_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

  assign dp_data_in1      = dp_data_in1_q;
  assign dp_data_in2      = dp_data_in2_q;
  assign dp_kernel_enable = dp_kernel_q;
  assign dp_clk_en        = dp_clk_en_q;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_eval_scheduler.sv
// Bench for eval_scheduler: instance A uses default parameters, instance B
// uses DP_LAT=3, WAKE_CYC=1. Each has an adder stub delayed by DP_LAT.
module tb_eval_scheduler;
  import eval_pkg::*;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eval_scheduler_if if_a ();
  eval_scheduler_if if_b ();

  logic [7:0] a_d1, a_d2, a_res, b_d1, b_d2, b_res;
  logic       a_ke, a_clk_en, b_ke, b_clk_en;

  eval_scheduler #(.DP_LAT(LAT_A), .WAKE_CYC(2), .IDLE_HOLD(4)) u_dut_a (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_if           (if_a),
    .dp_data_in1      (a_d1),
    .dp_data_in2      (a_d2),
    .dp_kernel_enable (a_ke),
    .dp_clk_en        (a_clk_en),
    .dp_result        (a_res)
  );

  eval_scheduler #(.DP_LAT(LAT_B), .WAKE_CYC(1), .IDLE_HOLD(4)) u_dut_b (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_if           (if_b),
    .dp_data_in1      (b_d1),
    .dp_data_in2      (b_d2),
    .dp_kernel_enable (b_ke),
    .dp_clk_en        (b_clk_en),
    .dp_result        (b_res)
  );

  // Datapath stubs: sum of operands, delayed DP_LAT cycles.
  logic [7:0] stub_b [3];
  always @(posedge clk) begin
    a_res     <= a_d1 + a_d2;
    stub_b[0] <= b_d1 + b_d2;
    stub_b[1] <= stub_b[0];
    stub_b[2] <= stub_b[1];
  end
  assign b_res = stub_b[2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rsp_cnt_a = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  typedef struct {
    logic [1:0] onehot;
    logic [7:0] data;
    int         acc_cyc;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  // Scoreboard: push at the negedge before an accepting edge, pop on strobe.
  task automatic mon(input int inst, input logic [1:0] v, input logic [1:0] rdy,
                     input logic [15:0] d1, input logic [15:0] d2,
                     input logic [1:0] rv, input logic [7:0] rd, input int lat);
    exp_t  e;
    logic [1:0] g;
    int    k;
    int    sz;
    string nm;
    nm = (inst == 0) ? "a" : "b";
    if (!rst_n) begin
      if (inst == 0) sb_a.delete(); else sb_b.delete();
      return;
    end
    g = v & rdy;
    if (g != 2'b00) begin
      k = g[1] ? 1 : 0;
      e.onehot  = g;
      e.data    = d1[8*k +: 8] + d2[8*k +: 8];
      e.acc_cyc = cyc + 1;
      if (inst == 0) sb_a.push_back(e); else sb_b.push_back(e);
    end
    if (rv != 2'b00) begin
      if (inst == 0) rsp_cnt_a++;
      sz = (inst == 0) ? sb_a.size() : sb_b.size();
      if (sz == 0) begin
        chk({nm, "_rsp_unexpected"}, 32'(rv), 0);
      end else begin
        e = (inst == 0) ? sb_a.pop_front() : sb_b.pop_front();
        chk({nm, "_rsp_tag"}, 32'(rv), 32'(e.onehot));
        chk({nm, "_rsp_data"}, 32'(rd), 32'(e.data));
        chk({nm, "_rsp_lat"}, 32'(cyc - e.acc_cyc), 32'(lat + 1));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, if_a.req_valid, if_a.req_ready, if_a.req_data1, if_a.req_data2,
        if_a.rsp_valid, if_a.rsp_data, LAT_A);
    mon(1, if_b.req_valid, if_b.req_ready, if_b.req_data1, if_b.req_data2,
        if_b.rsp_valid, if_b.rsp_data, LAT_B);
  end

  // Present one op on A, hold until accepted (bounded); returns 1ns after
  // the accepting edge with the request withdrawn.
  task automatic issue_a(input logic [1:0] sel, input logic [15:0] d1, input logic [15:0] d2);
    int waited = 0;
    bit done   = 1'b0;
    if_a.req_valid = sel;
    if_a.req_data1 = d1;
    if_a.req_data2 = d2;
    while (!done && waited < 40) begin
      @(negedge clk);
      done = |(if_a.req_valid & if_a.req_ready);
      @(posedge clk); #1;
      waited++;
    end
    if_a.req_valid = 2'b00;
    chk("issue_accepted", 32'(done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  logic [1:0] exp_g [4];
  int n_g;
  int budget;
  int rsp_before;

  initial begin
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    if_a.req_valid = '0; if_a.req_data1 = '0; if_a.req_data2 = '0; if_a.req_kernel = '0;
    if_b.req_valid = '0; if_b.req_data1 = '0; if_b.req_data2 = '0; if_b.req_kernel = '0;

    // Reset and idle
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_clk_en", 32'(a_clk_en), 0);
    chk("rst_ready", 32'(if_a.req_ready), 0);
    chk("rst_rsp_valid", 32'(if_a.rsp_valid), 0);
    chk("rst_dp_in1", 32'(a_d1), 0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("idle_clk_en", 32'(a_clk_en), 0);
    chk("idle_clk_en_b", 32'(b_clk_en), 0);
    chk("idle_dp_in2", 32'(a_d2), 0);
    chk("idle_rsp_data", 32'(if_a.rsp_data), 0);

    // Wake with defaults
    if_a.req_valid  = 2'b01;
    if_a.req_data1  = 16'h0003;
    if_a.req_data2  = 16'h000F;
    if_a.req_kernel = 2'b01;
    chk("wake_rdy_idle", 32'(if_a.req_ready), 0);
    @(posedge clk); #1;
    chk("wake_clk_en", 32'(a_clk_en), 1);
    chk("wake_rdy_c0", 32'(if_a.req_ready), 0);
    @(posedge clk); #1;
    chk("wake_rdy_c1", 32'(if_a.req_ready), 0);
    @(posedge clk); #1;
    chk("wake_rdy_c2", 32'(if_a.req_ready), 1);
    @(posedge clk); #1;
    if_a.req_valid = 2'b00;
    chk("wake_dp_in1", 32'(a_d1), 32'h03);
    chk("wake_dp_in2", 32'(a_d2), 32'h0F);
    chk("wake_dp_kernel", 32'(a_ke), 1);
    if_a.req_kernel = 2'b00;
    repeat (4) @(posedge clk); #1;
    chk("wake_sb_drained", 32'(sb_a.size()), 0);

    // Contention from a fresh pointer
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    if_a.req_data1 = 16'h2010;
    if_a.req_data2 = 16'h0201;
    if_a.req_valid = 2'b11;
    n_g = 0;
    budget = 0;
    while (n_g < 4 && budget < 40) begin
      @(negedge clk);
      if (|(if_a.req_valid & if_a.req_ready)) begin
        chk($sformatf("cont_gnt%0d", n_g), 32'(if_a.req_ready), 32'(exp_g[n_g]));
        n_g++;
      end
      @(posedge clk); #1;
      budget++;
      if (n_g == 4) if_a.req_valid = 2'b00;
    end
    if_a.req_valid = 2'b00;
    chk("cont_grant_count", 32'(n_g), 4);

    // Gate-off: two cycles in flight, then four idle cycles
    repeat (5) @(posedge clk); #1;
    chk("gate_hold", 32'(a_clk_en), 1);
    @(posedge clk); #1;
    chk("gate_off", 32'(a_clk_en), 0);
    chk("gate_sb_drained", 32'(sb_a.size()), 0);

    // Gate-off cancelled by a request on the terminal idle cycle
    issue_a(2'b10, 16'h0500, 16'h0700);
    repeat (5) @(posedge clk); #1;
    chk("late_pre_en", 32'(a_clk_en), 1);
    if_a.req_valid = 2'b10;
    if_a.req_data1 = 16'h4000;
    if_a.req_data2 = 16'h0300;
    @(negedge clk);
    chk("late_gnt", 32'(if_a.req_ready), 2);
    @(posedge clk); #1;
    if_a.req_valid = 2'b00;
    chk("late_en_hold", 32'(a_clk_en), 1);
    chk("late_dp_in1", 32'(a_d1), 32'h40);
    repeat (4) @(posedge clk); #1;
    chk("late_sb_drained", 32'(sb_a.size()), 0);

    // Reset mid-flight
    issue_a(2'b01, 16'h0011, 16'h0022);
    rsp_before = rsp_cnt_a;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_clk_en", 32'(a_clk_en), 0);
    chk("mid_rsp_valid", 32'(if_a.rsp_valid), 0);
    chk("mid_dp_in1", 32'(a_d1), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk); #1;
    chk("mid_no_rsp", 32'(rsp_cnt_a - rsp_before), 0);
    chk("mid_clk_en_idle", 32'(a_clk_en), 0);

    // Parameter sweep instance: DP_LAT=3, WAKE_CYC=1
    if_b.req_valid  = 2'b10;
    if_b.req_data1  = 16'h0900;
    if_b.req_data2  = 16'h0100;
    if_b.req_kernel = 2'b10;
    @(posedge clk); #1;
    chk("b_wake_clk_en", 32'(b_clk_en), 1);
    chk("b_wake_rdy_c0", 32'(if_b.req_ready), 0);
    @(posedge clk); #1;
    chk("b_wake_rdy_c1", 32'(if_b.req_ready), 2);
    @(posedge clk); #1;
    if_b.req_valid = 2'b00;
    chk("b_dp_kernel", 32'(b_ke), 1);
    repeat (8) @(posedge clk); #1;
    chk("b_sb_drained", 32'(sb_b.size()), 0);
    chk("a_sb_final", 32'(sb_a.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eval_scheduler.md
Name: eval_scheduler

Overview:
- Front-end controller for the 8-bit evaluation datapath (ROM lookup plus adder pipeline). It arbitrates two requesters round-robin and issues one operation per cycle onto the datapath inputs.
- It tracks in-flight operations so each result returns to its originator.
- It owns the datapath clock-gate enable: gated off when idle, woken with a settle delay before the first issue.

Parameters:
- DP_LAT, 1, cycles from the edge that drives dp_* to dp_result being valid (1..4).
- WAKE_CYC, 2, cycles dp_clk_en is held high before the first issue after wake (1..15).
- IDLE_HOLD, 4, consecutive idle cycles with the pipe empty before gating off (1..15).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester operation valid.
- req_ready  out  2  per-requester accept (one-hot or zero).
- req_data1  in  16  operand 1; requester i uses bits [8i+7:8i].
- req_data2  in  16  operand 2; same packing.
- req_kernel  in  2  per-requester kernel_enable mode bit.
- dp_data_in1  out  8  registered operand 1 to the datapath.
- dp_data_in2  out  8  registered operand 2 to the datapath.
- dp_kernel_enable  out  1  registered mode to the datapath.
- dp_clk_en  out  1  registered datapath clock-gate enable.
- dp_result  in  8  datapath result.
- rsp_valid  out  2  one-hot response strobe, 1 cycle; no backpressure.
- rsp_data  out  8  registered result.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0; rr pointer=0 (requester 0 favoured); in-flight tracker cleared.
  - Assertion mid-operation drops every in-flight op; no rsp_valid is ever produced for them.
- States: IDLE, WAKE, ACTIVE.
- IDLE:
  - dp_clk_en=0, req_ready=0.
  - Any req_valid bit -> WAKE; dp_clk_en rises on that same edge.
- WAKE:
  - dp_clk_en=1, req_ready=0; a counter runs 0..WAKE_CYC-1.
  - At terminal count -> ACTIVE. Requests are held by the requesters, not latched.
- ACTIVE:
  - dp_clk_en=1.
  - Grant: req_ready is combinational from req_valid and the rr pointer.
    - Only one requester valid: it is granted.
    - Both valid: the requester selected by the pointer is granted.
    - After any grant the pointer moves to the other requester.
  - Handshake: a transfer occurs at an edge where req_valid[i] and req_ready[i] are both 1. At that edge dp_data_in1/dp_data_in2/dp_kernel_enable load requester i's operands.
  - Cycles without a transfer: dp_* hold their last values.
- Tracker:
  - DP_LAT+1 deep shift of {valid, tag}, advanced every cycle while dp_clk_en=1.
  - An op accepted at edge E0 has dp_result sampled at edge E0+DP_LAT+1. rsp_data gets that value and rsp_valid[tag]=1 for the following cycle only.
  - Request-to-response latency is DP_LAT+1 cycles; back-to-back issue gives back-to-back responses in issue order.
- Gate-off:
  - The idle counter increments in cycles with no req_valid and an empty tracker; any request or in-flight op clears it.
  - Reaching IDLE_HOLD -> IDLE; dp_clk_en falls on that edge.
  - A req_valid arriving on the terminal-count cycle wins: stay ACTIVE, counter cleared, grant proceeds normally.
- dp_clk_en never drops while the tracker holds a valid entry.
- Counters saturate at terminal count and never wrap.
- Operands pass through unmodified; no arithmetic is done in this block.

Decomposition:
- Shared package eval_pkg:
  - state encoding: IDLE=2'd0, WAKE=2'd1, ACTIVE=2'd2;
  - NUM_REQ=2, DATA_W=8;
  - tag width constant.
- One sub-module, rr_arbiter2: 2-way round-robin grant with pointer update on grant. The FSM, tracker and gating stay in eval_scheduler.

Test Plan:
- Bench stub: dp_result = dp_data_in1 + dp_data_in2, delayed by DP_LAT cycles.
- Reset/idle: hold rst_n=0, then release with no requests -> all outputs 0, dp_clk_en=0 indefinitely.
- Wake (defaults): req_valid=2'b01, data1=0x03, data2=0x0F:
  - dp_clk_en=1 next edge;
  - req_ready[0]=1 exactly WAKE_CYC=2 cycles later;
  - rsp_valid=2'b01, rsp_data=0x12, 2 cycles after accept.
- Contention: both requesters valid for 4 cycles, data1 = 0x10/0x20, data2 = 0x01/0x02:
  - grants alternate 0,1,0,1;
  - rsp_data sequence 0x11,0x22,0x11,0x22 with matching one-hot tags.
- Gate-off: after the last response, no requests -> dp_clk_en falls after exactly IDLE_HOLD=4 idle cycles.
  - Repeat with req_valid[1] raised on the 4th idle cycle -> dp_clk_en stays 1 and a grant occurs.
- Reset mid-flight: accept an op, pull rst_n low 1 cycle later -> outputs clear immediately (async) and no rsp_valid ever appears.
- Parameter sweep: DP_LAT=3, WAKE_CYC=1 -> response exactly 4 cycles after accept; ready 1 cycle after wake.
